// File: rtl/d_flipflop.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// d_flipflop
//
// Positive-edge D-type register with asynchronous active-low reset. This is
// the basic storage primitive for pipeline stages, flags and synchroniser
// building blocks. The output comes straight from the register. There is no
// combinational path from d to q.
//
// Parameters
//   WIDTH        bit width of d and q
//   RESET_VALUE  value forced onto q while reset is asserted
//
// Ports
//   clk  in   1      clock; state changes only on its rising edge
//   rst  in   1      asynchronous reset, active-low (0 = reset asserted)
//   d    in   WIDTH  data input, sampled on the rising edge of clk
//   q    out  WIDTH  registered data output
// -----------------------------------------------------------------------------
module d_flipflop #(
   parameter int unsigned      WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Reset is tested first, so it overrides any clock edge that arrives while
   // it is low. This includes an edge that coincides with the release of
   // reset. Releasing reset does not wake this block, so q only changes on the
   // next rising clk edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= RESET_VALUE;
      end else begin
         // NOTE: non-blocking so that a d change coincident with the edge is
         // sampled at its pre-edge value, as every other register sees it.
         q <= d;
      end
   end

endmodule

// File: tb/tb_d_flipflop.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// tb_d_flipflop
//
// Self-checking bench for d_flipflop. It uses two instances:
//   dut1 : default parameters (WIDTH = 1, RESET_VALUE = 0)
//   dut8 : WIDTH = 8, RESET_VALUE = 8'hA5
//
// The driver runs one clock cycle at a time. Each cycle is described by:
//   - a reset level
//   - data values
//   - optional extras: a d glitch in the low phase, reset released exactly on
//     the rising edge, and a d change coincident with the edge
//
// As the driver issues stimulus, it pushes the value q must show at each
// sample point onto a scoreboard queue and fires sample_ev. A separate
// monitor pops the queue and compares the entry against both DUT outputs.
//
// The expected q comes from the register's defining rules:
//   - a low reset forces RESET_VALUE at once
//   - a rising edge taken with reset high loads the d seen before the edge
//   - nothing else moves q
// -----------------------------------------------------------------------------
module tb_d_flipflop;

   localparam logic       RV1 = 1'b0;
   localparam logic [7:0] RV8 = 8'hA5;

   logic       clk;
   logic       rst;
   logic       d1;
   logic       q1;
   logic [7:0] d8;
   logic [7:0] q8;

   d_flipflop dut1 (
      .clk (clk),
      .rst (rst),
      .d   (d1),
      .q   (q1)
   );

   d_flipflop #(
      .WIDTH       (8),
      .RESET_VALUE (RV8)
   ) dut8 (
      .clk (clk),
      .rst (rst),
      .d   (d8),
      .q   (q8)
   );

   // Period 10 ns, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------------------------------------------------------- scoreboard
   typedef struct {
      logic       exp1;
      logic [7:0] exp8;
      string      tag;
   } sb_item_t;

   sb_item_t sb[$];
   event     sample_ev;
   int       checks   = 0;
   int       failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Monitor: pops one expectation per sample request and compares both DUTs.
   initial begin
      sb_item_t it;
      forever begin
         @(sample_ev);
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd0, 32'd1);
         end else begin
            it = sb.pop_front();
            check({it.tag, "_q1"}, {31'd0, q1}, {31'd0, it.exp1});
            check({it.tag, "_q8"}, {24'd0, q8}, {24'd0, it.exp8});
         end
      end
   end

   // ---------------------------------------------------------------- model
   logic       exp1;     // value q1 should hold now
   logic [7:0] exp8;     // value q8 should hold now
   logic       rst_prev; // reset level at the end of the previous cycle

   task automatic expect_now(input string tag);
      sb_item_t it;
      it.exp1 = exp1;
      it.exp8 = exp8;
      it.tag  = tag;
      sb.push_back(it);
      ->sample_ev;
   endtask

   // One clock cycle, starting at the falling edge at time T:
   //   T+1    sample the result of the previous rising edge
   //   T+2    apply rst/d; a falling rst is checked at T+3 (asynchronous)
   //   T+3/4  optional d glitch, then a hold check at T+4
   //   T+5    rising edge; optionally release rst or change d at the edge
   task automatic run_cycle(input logic r, input logic dv, input logic [7:0] dv8,
                            input bit glitch, input bit rise_at_edge, input bit d_at_edge);
      @(negedge clk);
      #1 expect_now("edge");
      #1;
      rst = r;
      d1  = dv;
      d8  = dv8;
      if (!r) begin
         exp1 = RV1;
         exp8 = RV8;
      end
      #1;
      if (!r && rst_prev) expect_now("async");
      if (glitch) begin
         d1 = ~dv;
         d8 = ~dv8;
      end
      #1;
      if (glitch) begin
         d1 = dv;
         d8 = dv8;
         expect_now("hold");
      end
      if (rise_at_edge && !r) begin
         // Release in a later region of the edge timestep than the register's
         // evaluation: the edge still sees reset low, so reset wins.
         @(posedge clk);
         #0;
         rst = 1'b1;
      end else if (r) begin
         exp1 = dv;
         exp8 = dv8;
         if (d_at_edge) begin
            @(posedge clk);
            #0;
            d1 = ~dv;
            d8 = ~dv8;
         end
      end
      rst_prev = (rise_at_edge && !r) ? 1'b1 : r;
   endtask

   // ---------------------------------------------------------------- stimulus
   typedef struct {
      logic       r;
      logic       dv;
      logic [7:0] dv8;
      bit         glitch;
      bit         rise;
      bit         dedge;
   } cyc_t;

   cyc_t directed[$] = '{
      // reset held, d toggling: q stays at reset value
      '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0},
      // release and capture, then follow d
      '{1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0},
      // mid-cycle asynchronous assert with d = 1
      '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0},
      // glitches within the low phase do not reach q
      '{1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'h7E, 1'b1, 1'b0, 1'b0},
      // reset released exactly on a rising edge: reset wins that edge
      '{1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b1, 8'h56, 1'b0, 1'b0, 1'b0},
      // d changing on the edge: pre-edge value is captured
      '{1'b1, 1'b0, 8'h99, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1}
   };

   initial begin
      cyc_t c;
      rst      = 1'b1;
      d1       = 1'b0;
      d8       = 8'h00;
      exp1     = RV1;
      exp8     = RV8;
      rst_prev = 1'b0;
      // Power-up value is unknown; assert reset and check it acts at once.
      #1 rst = 1'b0;
      #1 expect_now("por");

      foreach (directed[i]) begin
         c = directed[i];
         run_cycle(c.r, c.dv, c.dv8, c.glitch, c.rise, c.dedge);
      end

      for (int i = 0; i < 300; i++) begin
         c.r      = ($urandom_range(7) != 0);
         c.dv     = 1'($urandom);
         c.dv8    = 8'($urandom);
         c.glitch = ($urandom_range(3) == 0);
         c.rise   = !c.r && ($urandom_range(1) == 0);
         c.dedge  = c.r && ($urandom_range(3) == 0);
         run_cycle(c.r, c.dv, c.dv8, c.glitch, c.rise, c.dedge);
      end

      @(negedge clk);
      #1 expect_now("final");
      #1 check("sb_drain", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog: the run is a few thousand ns; anything far beyond that is a hang.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "testbench timed out");
   end

endmodule

// File: doc/d_flipflop.md
Name: d_flipflop

Overview:
Single-bit (width-parameterisable) positive-edge D-type register with asynchronous active-low reset. Basic storage primitive for pipeline stages, flags and synchroniser building blocks. Output is registered only, with no combinational path from d to q.

Parameters:
WIDTH, 1, bit width of d and q.
RESET_VALUE, 0 (WIDTH bits), value loaded into q while reset is asserted.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous reset, active-low (0 = reset asserted, 1 = normal operation).
d    input  WIDTH  data input, sampled on rising clk edge.
q    output WIDTH  registered data output.

Behaviour:
- One clock domain (clk), one asynchronous active-low reset (rst).
- Reset assertion:
  - rst falling to 0 forces q = RESET_VALUE (default 0) immediately.
  - No clock edge is required; the only delay is simulation delta.
- Reset held:
  - While rst = 0, q holds RESET_VALUE.
  - Rising edges of clk are ignored; d has no effect.
- Normal operation (rst = 1):
  - On each rising edge of clk, q <= d.
  - q is constant between edges.
  - Latency: 1 clock. d sampled at edge N appears on q immediately after edge N.
- Reset release:
  - rst rising to 1 does not itself change q.
  - The first rising clk edge with rst = 1 captures d.
  - If rst and clk rise together, reset wins for that edge and q stays RESET_VALUE.
- Simultaneous events:
  - Reset has absolute priority over clock at all times.
  - A change on d coincident with a clk edge is sampled using the pre-edge value (standard non-blocking register semantics).
- Falling clk edges: no effect.
- Power-up before any reset: q is X in simulation. Users must apply reset; no initial value is guaranteed in hardware.
- No enable, no synchronous clear, no scan.
- Implementation: a single always block sensitive to posedge clk and negedge rst, using non-blocking assignment.

Test Plan:
Clock period 10 ns, rising edges at 5, 15, 25, ... ns.
- Reset hold: rst = 0, d toggling 0/1 across several edges -> q = 0 throughout.
- Capture after release: at t = 10 set rst = 1, d = 1 -> q = 1 after the edge at 15. Then d = 0 at t = 20 -> q = 0 after the edge at 25.
- Asynchronous assert: with q = 1 (rst = 1, d = 1 captured), drop rst to 0 at t = 32, mid-cycle -> q = 0 at t = 32, before the next edge. q stays 0 at the edge at 35 even with d = 1.
- Hold between edges: rst = 1, d toggles 1 -> 0 -> 1 within a single low clk phase -> q unchanged until the next rising edge, then equals d at that edge.
- Release/edge coincidence: rst rises exactly at a rising clk edge with d = 1 -> q remains 0 for that edge and becomes 1 at the following edge.
- WIDTH = 8, RESET_VALUE = 8'hA5: during reset q = 8'hA5. After release, d = 8'h3C -> q = 8'h3C after the next edge.
